// File: rtl/core_pkg.sv
// ============================================================================
//  Module : core_pkg
//  Brief  : Shared types and constants for the decode-stage hazard scheduler.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  localparam int HAZ_PIPE_DEPTH = 3;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 32;

  typedef enum logic [0:0] {
    HZ_RUN   = 1'b0,
    HZ_FLUSH = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } hz_slot_t;

endpackage

`default_nettype wire

// File: rtl/hazard_slot_pipe.sv
// ============================================================================
//  Module : hazard_slot_pipe
//  Brief  : Shift pipe of in-flight destination registers (slot0 = EX).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_slot_pipe
  import core_pkg::*;
#(
  parameter int DEPTH = HAZ_PIPE_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv_i,
  input  hz_slot_t                  new_i,
  output hz_slot_t [DEPTH-1:0]      slots_o,
  output logic     [NUM_REGS-1:0]   busy_o
);

  hz_slot_t [DEPTH-1:0] slots_q;

  // The oldest slot falls off the top on advance: that is the WB retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
    end else if (adv_i) begin
      slots_q <= {slots_q[DEPTH-2:0], new_i};
    end
  end

  always_comb begin
    busy_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slots_q[k].valid) begin
        busy_o[slots_q[k].rd] = 1'b1;
      end
    end
    busy_o[0] = 1'b0;
  end

  assign slots_o = slots_q;

endmodule

`default_nettype wire

// File: rtl/id_hazard_scheduler.sv
// ============================================================================
//  Module : id_hazard_scheduler
//  Brief  : Decode-stage issue control with RAW/WAW stall and redirect squash.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module id_hazard_scheduler
  import core_pkg::*;
#(
  parameter int PIPE_DEPTH   = HAZ_PIPE_DEPTH,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      use_rs1_i,
  input  logic                      use_rs2_i,
  input  logic                      RegWrite_i,
  input  logic                      ex_ready_i,
  input  logic                      flush_i,
  output logic                      issue_o,
  output logic                      stall_o,
  output logic                      bubble_o,
  output logic [NUM_REGS-1:0]       busy_o
);

  localparam logic [1:0] C_FLUSH_LOAD = 2'(FLUSH_CYCLES);

  hz_state_e                 state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  hz_slot_t [PIPE_DEPTH-1:0] slots;
  hz_slot_t                  new_slot;
  logic [NUM_REGS-1:0]       busy;
  logic                      hazard;

  hazard_slot_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (ex_ready_i),
    .new_i   (new_slot),
    .slots_o (slots),
    .busy_o  (busy)
  );

  // WB slot is included: the register file does not bypass same-cycle writes.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (slots[k].valid && (slots[k].rd != '0)) begin
        if ((use_rs1_i  && (slots[k].rd == rs1_addr_i)) ||
            (use_rs2_i  && (slots[k].rd == rs2_addr_i)) ||
            (RegWrite_i && (slots[k].rd == rd_addr_i))) begin
          hazard = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HZ_RUN: begin
        if (flush_i) begin
          state_d = HZ_FLUSH;
          cnt_d   = C_FLUSH_LOAD;
        end
      end
      HZ_FLUSH: begin
        if (flush_i) begin
          cnt_d = C_FLUSH_LOAD;
        end else if (ex_ready_i) begin
          if (cnt_q == 2'd1) begin
            state_d = HZ_RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      default: begin
        state_d = HZ_RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // A killed instruction is dropped rather than held, so no stall on flush.
  always_comb begin
    issue_o  = 1'b0;
    stall_o  = 1'b0;
    bubble_o = 1'b0;
    busy_o   = '0;
    if (!rst) begin
      issue_o  = (state_q == HZ_RUN) && id_valid_i && ex_ready_i && !hazard && !flush_i;
      stall_o  = (state_q == HZ_RUN) && !flush_i && id_valid_i && !issue_o;
      bubble_o = ex_ready_i && !issue_o;
      busy_o   = busy;
    end
  end

  always_comb begin
    new_slot       = '0;
    new_slot.valid = issue_o && RegWrite_i && (rd_addr_i != '0);
    new_slot.rd    = rd_addr_i;
  end

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_scheduler.sv
// ============================================================================
//  Module : tb_id_hazard_scheduler
//  Brief  : Directed and random checks of id_hazard_scheduler against a model.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_id_hazard_scheduler;

  localparam int DEPTH  = 3;
  localparam int FLUSHN = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, use_rs1_i, use_rs2_i, RegWrite_i, ex_ready_i, flush_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        issue_o, stall_o, bubble_o;
  logic [31:0] busy_o;

  int n_vec = 0;
  int n_err = 0;

  // Model: pending destination per stage (index 0 = EX), -1 when empty.
  int pend[DEPTH];
  bit flushing;
  int flush_left;
  bit e_issue, e_stall, e_bubble;
  logic [31:0] e_busy;

  always #5 clk = ~clk;

  id_hazard_scheduler #(
    .PIPE_DEPTH   (DEPTH),
    .FLUSH_CYCLES (FLUSHN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid_i (id_valid_i),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rd_addr_i  (rd_addr_i),
    .use_rs1_i  (use_rs1_i),
    .use_rs2_i  (use_rs2_i),
    .RegWrite_i (RegWrite_i),
    .ex_ready_i (ex_ready_i),
    .flush_i    (flush_i),
    .issue_o    (issue_o),
    .stall_o    (stall_o),
    .bubble_o   (bubble_o),
    .busy_o     (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare combinational outputs, advance model.
  task automatic step(input bit r, input bit v, input int s1, input bit u1,
                      input int s2, input bit u2, input int d, input bit w,
                      input bit rdy, input bit fl);
    bit haz;
    @(negedge clk);
    rst = r; id_valid_i = v; rs1_addr_i = 5'(s1); use_rs1_i = u1;
    rs2_addr_i = 5'(s2); use_rs2_i = u2; rd_addr_i = 5'(d); RegWrite_i = w;
    ex_ready_i = rdy; flush_i = fl;
    #1;
    haz = 1'b0;
    e_busy = '0;
    foreach (pend[k]) begin
      if (pend[k] > 0) begin
        e_busy[pend[k]] = 1'b1;
        if ((u1 && s1 == pend[k]) || (u2 && s2 == pend[k]) || (w && d == pend[k])) haz = 1'b1;
      end
    end
    if (r) e_busy = '0;
    e_issue  = !r && !flushing && v && rdy && !haz && !fl;
    e_stall  = !r && !flushing && !fl && v && !e_issue;
    e_bubble = !r && rdy && !e_issue;
    check("issue",  {31'd0, issue_o},  {31'd0, e_issue});
    check("stall",  {31'd0, stall_o},  {31'd0, e_stall});
    check("bubble", {31'd0, bubble_o}, {31'd0, e_bubble});
    check("busy",   busy_o,            e_busy);
    if (r) begin
      foreach (pend[k]) pend[k] = -1;
      flushing   = 1'b0;
      flush_left = 0;
    end else begin
      if (rdy) begin
        for (int k = DEPTH - 1; k > 0; k--) pend[k] = pend[k-1];
        pend[0] = (e_issue && w && d != 0) ? d : -1;
      end
      if (!flushing) begin
        if (fl) begin flushing = 1'b1; flush_left = FLUSHN; end
      end else if (fl) begin
        flush_left = FLUSHN;
      end else if (rdy) begin
        if (flush_left == 1) flushing = 1'b0;
        else flush_left--;
      end
    end
  endtask

  initial begin
    int stalls;
    foreach (pend[k]) pend[k] = -1;
    flushing = 1'b0;
    flush_left = 0;

    // reset                 r v s1 u1 s2 u2 rd w rdy fl
    step(1, 1, 1, 1, 2, 1, 3, 1, 1, 0);
    step(1, 1, 1, 1, 2, 1, 3, 1, 1, 0);

    // RAW: addi x5 then add x6,x5,x1 stalls for EX, MEM and WB
    step(0, 1, 0, 1, 0, 0, 5, 1, 1, 0);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 5, 1, 1, 1, 6, 1, 1, 0);
      if (stall_o) stalls++;
    end
    check("raw_stall_count", 32'(stalls), 32'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // x0 never hazards; independent writers issue back to back
    step(0, 1, 2, 1, 0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0, 1, 7, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 2, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 3, 1, 1, 0);

    // frozen pipe with x5 in MEM
    step(0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 5, 1, 0, 0, 9, 1, 0, 0);
    check("frozen_busy5", {31'd0, busy_o[5]}, 32'd1);
    step(0, 1, 5, 1, 0, 0, 9, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 5, 1, 0, 0, 9, 1, 1, 0);

    // redirect: jal x1 in EX, two wrong-path instructions dropped
    step(0, 1, 0, 0, 0, 0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 10, 1, 1, 1);
    check("flush_busy1", {31'd0, busy_o[1]}, 32'd1);
    step(0, 1, 0, 0, 0, 0, 11, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 12, 1, 1, 0);

    // WAW: lw x8 waits for addi x8
    step(0, 1, 0, 1, 0, 0, 8, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 2, 1, 0, 0, 8, 1, 1, 0);

    // reset mid-flush with a full pipe
    step(0, 1, 0, 0, 0, 0, 13, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 14, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 15, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 16, 1, 1, 1);
    step(1, 1, 0, 0, 0, 0, 16, 1, 1, 0);
    step(0, 1, 13, 1, 14, 1, 15, 1, 1, 0);
    check("post_reset_issue", {31'd0, issue_o}, 32'd1);

    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) < 2, $urandom_range(9) < 8,
           int'($urandom_range(7)), 1'($urandom),
           int'($urandom_range(7)), 1'($urandom),
           int'($urandom_range(7)), $urandom_range(9) < 7,
           $urandom_range(9) < 8, $urandom_range(99) < 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
